// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// request classification codes, default latency and the request checker.
package mem_responder_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  // Request classification, listed in checking priority order
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_BOTH  = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;

  // Edges from acceptance to MemReady when the parameter is left alone
  localparam int DEFAULT_LATENCY = 2;

  // Classify a request: both strobes first, then word alignment, then
  // whether the byte address falls outside the RAM.
  function automatic logic [1:0] classify_req(input logic        rd,
                                              input logic        wr,
                                              input logic [31:0] addr,
                                              input int          addr_bits);
    logic [31:0] high;
    logic [1:0]  code;
    high = addr >> (addr_bits + 2);
    if (rd && wr)
      code = ERR_BOTH;
    else if (addr[1:0] != 2'b00)
      code = ERR_ALIGN;
    else if (high != 32'd0)
      code = ERR_RANGE;
    else
      code = ERR_NONE;
    return code;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, 32-bit words, 2**ADDR_BITS deep.
// Read data is registered: rd reflects mem[addr] as of the last edge.
// Optional feature macro MEM_INIT_EN: when defined, contents are given a
// known all-zero image at time zero; otherwise the RAM powers up unknown.
module mem_array #(
  parameter int    ADDR_BITS = 8,
  parameter string INIT_FILE = "mem.hex"
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wd,
  output logic [31:0]          rd
);

  logic [31:0] mem [2**ADDR_BITS];

`ifdef MEM_INIT_EN
  // Power-up image; reset deliberately does not reload it
  initial begin
    for (int i = 0; i < 2**ADDR_BITS; i++)
      mem[i] = 32'd0;
  end
`else
  // No preload: unwritten words read back as X
`endif

  // Write-enable store plus registered read of the same address
  always_ff @(posedge clock) begin
    if (we)
      mem[addr] <= wd;
    rd <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle controller's MemRead/MemWrite
// strobes. Accepts a request in IDLE, waits LATENCY edges, performs the
// RAM access and pulses MemReady (qualified by MemError) for one cycle,
// then holds in HOLD until the strobes drop so a long strobe is not
// serviced twice. Optional feature macro MEM_INIT_EN (RAM preload) lives
// in mem_array.
//
// Handshake: a request is any cycle with MemRead|MemWrite high while
// MemBusy is low; it is sampled once on that edge and every input is
// ignored until MemBusy falls again. MemReady is a single-cycle pulse;
// MemError is meaningful only while MemReady is high.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int    ADDR_BITS = 8,
  parameter int    LATENCY   = DEFAULT_LATENCY,
  parameter string INIT_FILE = "mem.hex"
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] MemData,
  output logic        MemReady,
  output logic        MemBusy,
  output logic        MemError
);

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic [31:0]            data_nxt;
  logic                   busy_nxt, ready_nxt, error_nxt;
  logic                   req, latch, issue;
  logic [1:0]             err_code;

  logic [ADDR_BITS-1:0]   addr_q;
  logic [31:0]            wdata_q;
  logic                   write_q, err_q;

  logic [ADDR_BITS-1:0]   ram_addr;
  logic                   ram_we;
  logic [31:0]            ram_rd;

  assign req      = MemRead | MemWrite;
  assign err_code = classify_req(MemRead, MemWrite, Address, ADDR_BITS);

  // While idle the RAM reads the incoming word address so the registered
  // read data is ready even for LATENCY=1; afterwards the latched address
  // is used for both the read and the write.
  assign ram_addr = (state == S_IDLE) ? Address[ADDR_BITS+1:2] : addr_q;
  // Writes happen only on the response edge of a valid write, and never
  // on an edge where reset aborts the transaction.
  assign ram_we   = issue & write_q & ~err_q & ~reset;

  mem_array #(
    .ADDR_BITS (ADDR_BITS),
    .INIT_FILE (INIT_FILE)
  ) u_mem_array (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wd    (wdata_q),
    .rd    (ram_rd)
  );

  // Next-state and registered-output logic; issue marks the response edge
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = MemBusy;
    ready_nxt = 1'b0;
    error_nxt = MemError;
    data_nxt  = MemData;
    latch     = 1'b0;
    issue     = 1'b0;

    case (state)
      S_IDLE: begin
        if (req) begin
          latch    = 1'b1;
          busy_nxt = 1'b1;
          if (err_code != ERR_NONE) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_RESP;
          issue     = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        // A rejected request enters RESP straight from IDLE without a
        // response; it answers here, one edge after acceptance. Once the
        // pulse has been shown, move on and clear the qualifier.
        if (!MemReady) begin
          issue = 1'b1;
        end else begin
          state_nxt = S_HOLD;
          error_nxt = 1'b0;
        end
      end
      S_HOLD: begin
        if (!req) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
        error_nxt = 1'b0;
      end
    endcase

    if (issue) begin
      ready_nxt = 1'b1;
      error_nxt = err_q;
      if (!err_q && !write_q)
        data_nxt = ram_rd;
    end
  end

  // FSM state, latency counter and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      MemData  <= 32'd0;
      MemReady <= 1'b0;
      MemBusy  <= 1'b0;
      MemError <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      MemData  <= data_nxt;
      MemReady <= ready_nxt;
      MemBusy  <= busy_nxt;
      MemError <= error_nxt;
    end
  end

  // Request capture at acceptance; later input changes are ignored
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (latch) begin
      addr_q  <= Address[ADDR_BITS+1:2];
      wdata_q <= WriteData;
      write_q <= MemWrite;
      err_q   <= (err_code != ERR_NONE);
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one LATENCY=2 instance for function
// and error cases, plus LATENCY=1 and LATENCY=15 instances sharing the
// same inputs for the latency-boundary measurement.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = 32'd0;
  logic [31:0] WriteData = 32'd0;

  logic [31:0] md, md1, md15;
  logic        rdy, busy, err;
  logic        rdy1, busy1, err1;
  logic        rdy15, busy15, err15;

  int checks = 0;
  int failures = 0;

  // Per-transaction observations
  int          b0, re, np, es, ie;
  logic [31:0] ds;
  int          r1, r2, r15, e1, e15;

  // Clock
  always #5 clock = ~clock;

  mem_responder #(.ADDR_BITS(8), .LATENCY(2)) dut (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData),
    .MemData(md), .MemReady(rdy), .MemBusy(busy), .MemError(err)
  );

  mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut_lat1 (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData),
    .MemData(md1), .MemReady(rdy1), .MemBusy(busy1), .MemError(err1)
  );

  mem_responder #(.ADDR_BITS(8), .LATENCY(15)) dut_lat15 (
    .clock(clock), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData),
    .MemData(md15), .MemReady(rdy15), .MemBusy(busy15), .MemError(err15)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one request on the main instance. Edge 0 is the acceptance edge.
  // Strobes stay up hold_extra edges past the first MemReady, then drop;
  // idle_edges counts edges from the drop until MemBusy falls.
  task automatic run_txn(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int hold_extra,
                         output int busy0, output int ready_edge,
                         output int pulses, output int err_seen,
                         output logic [31:0] data_seen, output int idle_edges);
    busy0 = 0; ready_edge = -1; pulses = 0; err_seen = 0;
    data_seen = 32'd0; idle_edges = -1;
    MemRead = rd; MemWrite = wr; Address = addr; WriteData = wd;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (e == 0) busy0 = int'(busy);
      if (rdy === 1'b1) begin
        pulses++;
        if (ready_edge < 0) begin
          ready_edge = e;
          err_seen   = int'(err);
          data_seen  = md;
        end
      end
      if (ready_edge >= 0 && e >= ready_edge + hold_extra) break;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    WriteData = $urandom;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (rdy === 1'b1) pulses++;
      if (busy === 1'b0) begin
        idle_edges = e;
        break;
      end
    end
  endtask

  // Hard stop if something wedges the flow
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_data",  md,   32'd0);
    check("reset_ready", 32'(rdy),  32'd0);
    check("reset_busy",  32'(busy), 32'd0);
    check("reset_error", 32'(err),  32'd0);

    // Write 0xDEADBEEF to 0x10, strobe dropped right after MemReady
    run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, b0, re, np, es, ds, ie);
    check("wr10_busy0",  32'(b0), 32'd1);
    check("wr10_ready",  32'(re), 32'd2);
    check("wr10_pulses", 32'(np), 32'd1);
    check("wr10_error",  32'(es), 32'd0);
    check("wr10_idle",   32'(ie), 32'd2);

    // Read it back holding MemRead 3 extra edges
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 3, b0, re, np, es, ds, ie);
    check("rd10_ready",  32'(re), 32'd2);
    check("rd10_data",   ds,      32'hDEADBEEF);
    check("rd10_pulses", 32'(np), 32'd1);
    check("rd10_error",  32'(es), 32'd0);
    check("rd10_idle",   32'(ie), 32'd1);

    // Seed RAM[8], then issue both strobes at 0x20
    run_txn(1'b0, 1'b1, 32'h20, 32'h11112222, 0, b0, re, np, es, ds, ie);
    check("wr20_ready", 32'(re), 32'd2);
    check("wr20_error", 32'(es), 32'd0);
    run_txn(1'b1, 1'b1, 32'h20, 32'h55555555, 0, b0, re, np, es, ds, ie);
    check("both_ready", 32'(re), 32'd1);
    check("both_error", 32'(es), 32'd1);
    check("both_data",  ds,      32'hDEADBEEF);
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, 0, b0, re, np, es, ds, ie);
    check("rd20_data",  ds,      32'h11112222);
    check("rd20_error", 32'(es), 32'd0);

    // Misaligned and out-of-range reads
    run_txn(1'b1, 1'b0, 32'h12, 32'h0, 0, b0, re, np, es, ds, ie);
    check("align_ready", 32'(re), 32'd1);
    check("align_error", 32'(es), 32'd1);
    check("align_data",  ds,      32'h11112222);
    run_txn(1'b1, 1'b0, 32'h400, 32'h0, 1, b0, re, np, es, ds, ie);
    check("range_ready", 32'(re), 32'd1);
    check("range_error", 32'(es), 32'd1);
    check("range_data",  ds,      32'h11112222);

    // Top word of the RAM is in range
    run_txn(1'b0, 1'b1, 32'h3FC, 32'hA5A55A5A, 0, b0, re, np, es, ds, ie);
    check("wr3fc_error", 32'(es), 32'd0);
    run_txn(1'b1, 1'b0, 32'h3FC, 32'h0, 1, b0, re, np, es, ds, ie);
    check("rd3fc_data",  ds,      32'hA5A55A5A);
    check("rd3fc_ready", 32'(re), 32'd2);

    // Reset during the WAIT of a write to 0x30 must discard the write
    run_txn(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 0, b0, re, np, es, ds, ie);
    check("wr30_ready", 32'(re), 32'd2);
    MemWrite = 1'b1; Address = 32'h30; WriteData = 32'h0BADBAD0;
    tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1; MemWrite = 1'b0;
    tick();
    check("abort_data",  md,        32'd0);
    check("abort_ready", 32'(rdy),  32'd0);
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_error", 32'(err),  32'd0);
    reset = 1'b0;
    np = 0;
    repeat (3) begin
      tick();
      if (rdy === 1'b1) np++;
    end
    check("abort_no_pulse", 32'(np), 32'd0);
    run_txn(1'b1, 1'b0, 32'h30, 32'h0, 0, b0, re, np, es, ds, ie);
    check("rd30_data",  ds,      32'hCAFEF00D);
    check("rd30_ready", 32'(re), 32'd2);

    // Latency boundaries: let every instance settle, then one shared read
    MemRead = 1'b0; MemWrite = 1'b0;
    repeat (40) tick();
    MemRead = 1'b1; Address = 32'h10;
    r1 = -1; r2 = -1; r15 = -1; e1 = -1; e15 = -1;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (rdy1 === 1'b1 && r1 < 0) begin r1 = e; e1 = int'(err1); end
      if (rdy === 1'b1 && r2 < 0) r2 = e;
      if (rdy15 === 1'b1 && r15 < 0) begin r15 = e; e15 = int'(err15); end
    end
    MemRead = 1'b0;
    repeat (5) tick();
    check("lat1_ready",  32'(r1),  32'd1);
    check("lat2_ready",  32'(r2),  32'd2);
    check("lat15_ready", 32'(r15), 32'd15);
    check("lat1_error",  32'(e1),  32'd0);
    check("lat15_error", 32'(e15), 32'd0);
    check("lat15_idle",  32'(busy15), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
